// File: rtl/vending_pkg.sv
// Shared types for the vending controller: FSM states, coin codes and the
// code-to-value mapping used by both the controller and the change picker.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_1    = 2'd1;
  localparam logic [1:0] COIN_2    = 2'd2;
  localparam logic [1:0] COIN_3    = 2'd3;

  function automatic int coin_value(input logic [1:0] code, input int v1, input int v2,
                                    input int v3);
    case (code)
      COIN_1:  return v1;
      COIN_2:  return v2;
      COIN_3:  return v3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vending_ctrl_if.sv
// Coin acceptor / dispenser / change hopper signal bundle. master drives the
// coin-side inputs and hopper ready; slave is the controller.
interface vending_ctrl_if #(
  parameter int CREDIT_W = 8
);
  logic [1:0]          coin;
  logic                cancel;
  logic                chg_ready;
  logic                dispense;
  logic                chg_valid;
  logic [1:0]          chg_coin;
  logic                coin_rej;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin, cancel, chg_ready,
    input  dispense, chg_valid, chg_coin, coin_rej, credit, busy
  );

  modport slave (
    input  coin, cancel, chg_ready,
    output dispense, chg_valid, chg_coin, coin_rej, credit, busy
  );
endinterface

// File: rtl/vending_change_sel.sv
// Combinational picker: largest coin denomination whose value fits in the
// remaining credit, returned as code and value (COIN_NONE/0 when nothing fits).
module vending_change_sel
  import vending_pkg::*;
#(
  parameter int CREDIT_W  = 8,
  parameter int COIN1_VAL = 5,
  parameter int COIN2_VAL = 10,
  parameter int COIN3_VAL = 25
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          code,
  output logic [CREDIT_W-1:0] value
);

  logic [31:0] credit_w;
  assign credit_w = 32'(credit);

  always_comb begin
    code = COIN_NONE;
    if (credit_w >= 32'(COIN3_VAL))      code = COIN_3;
    else if (credit_w >= 32'(COIN2_VAL)) code = COIN_2;
    else if (credit_w >= 32'(COIN1_VAL)) code = COIN_1;
    value = CREDIT_W'(coin_value(code, COIN1_VAL, COIN2_VAL, COIN3_VAL));
  end

endmodule

// File: rtl/vending_ctrl.sv
// Parametrised vending controller: credit accumulation, one-cycle vend, change
// return over valid/ready. Optional refund on cancel under `VEND_CANCEL_EN.
//   state   | meaning
//   IDLE    | credit 0, waiting for first coin
//   COLLECT | 0 < credit < PRICE
//   VEND    | one-cycle dispense pulse, PRICE deducted on exit
//   CHANGE  | returning remaining credit one coin per handshake
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int CREDIT_W  = 8,
  parameter int PRICE     = 15,
  parameter int COIN1_VAL = 5,
  parameter int COIN2_VAL = 10,
  parameter int COIN3_VAL = 25
) (
  input logic           clk,
  input logic           rst_n,
  vending_ctrl_if.slave bus
);

  if (PRICE < 1 || CREDIT_W < 1 || CREDIT_W > 30 || PRICE >= (1 << CREDIT_W)) begin : g_bad_price
    $error("vending_ctrl: PRICE out of range for CREDIT_W");
  end
  if (!(COIN1_VAL > 0 && COIN1_VAL < COIN2_VAL && COIN2_VAL < COIN3_VAL)) begin : g_bad_order
    $error("vending_ctrl: coin values must be strictly increasing and positive");
  end
  if ((PRICE % COIN1_VAL) != 0 || (COIN2_VAL % COIN1_VAL) != 0 ||
      (COIN3_VAL % COIN1_VAL) != 0) begin : g_bad_multiple
    $error("vending_ctrl: PRICE and coin values must be multiples of COIN1_VAL");
  end

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit, credit_nx;
  logic                rej, rej_nx;
  logic [1:0]          sel_code;
  logic [CREDIT_W-1:0] sel_val;
  logic [31:0]         sum;
  logic                cancel_req;
  logic                coin_in;

`ifdef VEND_CANCEL_EN
  assign cancel_req = bus.cancel;
`else
  assign cancel_req = 1'b0;
`endif

  vending_change_sel #(
    .CREDIT_W (CREDIT_W),
    .COIN1_VAL(COIN1_VAL),
    .COIN2_VAL(COIN2_VAL),
    .COIN3_VAL(COIN3_VAL)
  ) u_change_sel (
    .credit(credit),
    .code  (sel_code),
    .value (sel_val)
  );

  // Summed at 32 bits so overflow of the credit register is visible in the upper bits.
  assign sum     = 32'(credit) + 32'(coin_value(bus.coin, COIN1_VAL, COIN2_VAL, COIN3_VAL));
  assign coin_in = (bus.coin != COIN_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      credit <= '0;
      rej    <= 1'b0;
    end else begin
      state  <= state_nx;
      credit <= credit_nx;
      rej    <= rej_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    rej_nx    = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (cancel_req && state == COLLECT) begin
          state_nx = CHANGE;
          rej_nx   = coin_in;
        end else if (coin_in) begin
          if (sum[31:CREDIT_W] != '0) begin
            rej_nx = 1'b1;
          end else begin
            credit_nx = sum[CREDIT_W-1:0];
            state_nx  = (sum >= 32'(PRICE)) ? VEND : COLLECT;
          end
        end
      end
      VEND: begin
        credit_nx = credit - CREDIT_W'(PRICE);
        state_nx  = (credit == CREDIT_W'(PRICE)) ? IDLE : CHANGE;
        rej_nx    = coin_in;
      end
      CHANGE: begin
        rej_nx = coin_in;
        if (bus.chg_ready) begin
          credit_nx = credit - sel_val;
          if (credit == sel_val) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.dispense  = (state == VEND);
  assign bus.chg_valid = (state == CHANGE);
  assign bus.chg_coin  = (state == CHANGE) ? sel_code : COIN_NONE;
  assign bus.coin_rej  = rej;
  assign bus.credit    = credit;
  assign bus.busy      = (state == VEND) || (state == CHANGE);

endmodule

// File: doc/vending_ctrl.md
# vending_ctrl

Parametrised vending controller, successor to the fixed two-coin vending FSM. Accepts three coin denominations and accumulates credit against a configurable price. Issues a one-cycle dispense pulse, then returns change coin-by-coin over a valid/ready handshake. Sits between the coin acceptor front end and the dispenser/change-hopper drivers.

## Interface
- CREDIT_W, 8: credit register width in value units
- PRICE, 15: product price; 1 ≤ PRICE < 2^CREDIT_W
- COIN1_VAL, 5: value of coin code 1; smallest denomination
- COIN2_VAL, 10: value of coin code 2
- COIN3_VAL, 25: value of coin code 3; COIN1_VAL < COIN2_VAL < COIN3_VAL
- Every value parameter (PRICE, COIN2_VAL, COIN3_VAL) is a multiple of COIN1_VAL; violation is an elaboration-time error.
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- coin  in  2  coin presented this cycle: 0 none, 1/2/3 denomination; one coin per cycle
- cancel  in  1  refund request (only with VEND_CANCEL_EN)
- chg_ready  in  1  hopper accepts the coin on chg_coin
- dispense  out  1  one-cycle vend pulse
- chg_valid  out  1  change coin offered
- chg_coin  out  2  denomination code of offered change coin
- coin_rej  out  1  one-cycle pulse: coin of previous cycle rejected and returned
- credit  out  CREDIT_W  current credit or remaining change
- busy  out  1  high in VEND and CHANGE

## Operation
- States:
  - IDLE: credit 0.
  - COLLECT: 0 < credit < PRICE.
  - VEND: exactly one cycle.
  - CHANGE: change being returned.
- IDLE/COLLECT:
  - A nonzero coin adds its value to credit.
  - If credit + value ≥ PRICE, go to VEND; otherwise go to COLLECT.
  - If the sum overflows CREDIT_W, reject the coin: credit unchanged, coin_rej pulses.
- VEND:
  - dispense = 1 and credit = PRICE is subtracted at the exiting edge.
  - Remainder > 0 goes to CHANGE; remainder 0 goes to IDLE.
- CHANGE:
  - chg_valid = 1.
  - chg_coin = largest denomination whose value ≤ credit.
  - On chg_valid && chg_ready, subtract that value.
  - When credit reaches 0, go to IDLE.
  - chg_coin and credit stay stable while chg_ready is low.
- A coin arriving in VEND or CHANGE is rejected: coin_rej pulses next cycle and credit is unchanged.
- Reset mid-operation clears the state to IDLE and credit to 0. Pending change is lost, and no dispense or change is emitted.

## Timing
- Reset values: dispense 0, chg_valid 0, chg_coin 0, coin_rej 0, credit 0, busy 0.
- All outputs are registered or decoded from registered state only. There are no combinational input-to-output paths.
- Coin at cycle t: credit updates at edge t+1.
- If the threshold is met at that edge, dispense is high during cycle t+1, and chg_valid is first high in cycle t+2.
- Change throughput: one coin per cycle while chg_ready is held high.
- coin_rej is high for exactly the cycle after the offending coin.

## Configuration
- VEND_CANCEL_EN defined:
  - cancel in COLLECT enters CHANGE with the full credit and no dispense.
  - cancel in IDLE, VEND or CHANGE is ignored.
  - cancel together with a coin in the same cycle: cancel wins, and the coin is rejected (coin_rej pulses).
- VEND_CANCEL_EN undefined:
  - cancel port is present but ignored.
  - Credit is held in COLLECT indefinitely.

## Structure
- Package vending_pkg holds:
  - the state enum (IDLE, COLLECT, VEND, CHANGE);
  - coin code localparams (COIN_NONE=0, COIN_1=1, COIN_2=2, COIN_3=3);
  - the function that maps a code to its value.
- Sub-module vending_change_sel: combinational largest-denomination picker. Input is the remaining credit; outputs are the code and its value. It is instanced once.

## Test plan
Defaults throughout: PRICE=15, coin values 5/10/25.
- Coin 1 then coin 2 -> credit 5, then 15; dispense pulses one cycle; no chg_valid; credit returns to 0; state IDLE.
- Coin 3 with chg_ready=1 -> dispense, then one change coin chg_coin=2 (10); credit 0 one cycle later.
- Coin 2, coin 2 with chg_ready=0 for 3 cycles -> dispense; chg_valid=1, chg_coin=1 held stable for 3 cycles; cleared on the first ready cycle.
- VEND_CANCEL_EN: coin 2 then cancel -> refund chg_coin=2; dispense never asserts. Same stimulus without the macro -> credit stays at 10.
- Coin presented during CHANGE -> coin_rej pulses the next cycle; credit sequence is unaffected.
- rst_n low mid-CHANGE -> every output is 0 immediately; after release, a coin 3 vends normally.
